// File: rtl/rpn_stack_ctrl_pkg.sv
// rtl/rpn_stack_ctrl_pkg.sv - shared types for the RPN stack controller
package rpn_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SHOW = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_AND = 2'd2,
    OP_OR  = 2'd3
  } opcode_t;

  typedef enum logic [1:0] {
    LK_NONE = 2'd0,
    LK_PUSH = 2'd1,
    LK_OP   = 2'd2
  } last_kind_t;

endpackage

// File: rtl/rpn_stack_ctrl_if.sv
// rtl/rpn_stack_ctrl_if.sv - command and status bundle between input conditioning and the controller
interface rpn_stack_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int SP_W = $clog2(DEPTH + 1);

  logic             Enter_pulse;
  logic             Undo_pulse;
  logic             IsOp;
  logic [1:0]       OpCode;
  logic [WIDTH-1:0] DataIn;
  logic [WIDTH-1:0] Top;
  logic [SP_W-1:0]  Sp;
  logic [1:0]       Status;
  logic             Full;
  logic             Empty;
  logic             Error;
  logic             Carry;
  logic             ToDisplaySel;
  logic             updateRes;

  modport master (
    output Enter_pulse, Undo_pulse, IsOp, OpCode, DataIn,
    input  Top, Sp, Status, Full, Empty, Error, Carry, ToDisplaySel, updateRes
  );

  modport slave (
    input  Enter_pulse, Undo_pulse, IsOp, OpCode, DataIn,
    output Top, Sp, Status, Full, Empty, Error, Carry, ToDisplaySel, updateRes
  );
endinterface

// File: rtl/rpn_stack_ctrl_alu.sv
// rtl/rpn_stack_ctrl_alu.sv - combinational add/sub/and/or with carry-borrow out
module rpn_alu
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  opcode_t          op,
  output logic [WIDTH-1:0] y,
  output logic             carry
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // The extra top bit of the difference is the borrow (a < b).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: {carry, y} = sum;
      OP_SUB: {carry, y} = diff;
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      default: ;
    endcase
  end
endmodule

// File: rtl/rpn_stack_ctrl.sv
// rtl/rpn_stack_ctrl.sv - RPN calculator controller: operand stack, one-level undo, result display control
module rpn_stack_ctrl
  import rpn_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            Reset_n,
  rpn_stack_ctrl_if.slave bus
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  state_t           state_q, state_d;
  last_kind_t       lk_q, lk_d;
  opcode_t          op_q, op_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic             err_q, err_d;
  logic             carry_q, carry_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic             wa_en, wb_en;
  logic [IDX_W-1:0] wa_idx, wb_idx;
  logic [WIDTH-1:0] wa_data, wb_data;
  logic [IDX_W-1:0] tos_idx, nos_idx, sp_idx;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  assign tos_idx = IDX_W'(sp_q - SP_W'(1));
  assign nos_idx = IDX_W'(sp_q - SP_W'(2));
  assign sp_idx  = IDX_W'(sp_q);

  // Operands stay in a_q/b_q after execution so the last op can be undone.
  rpn_alu #(.WIDTH(WIDTH)) u_alu (
    .a     (a_q),
    .b     (b_q),
    .op    (op_q),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_comb begin
    state_d = state_q;
    lk_d    = lk_q;
    op_d    = op_q;
    sp_d    = sp_q;
    err_d   = err_q;
    carry_d = carry_q;
    upd_d   = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    wa_en   = 1'b0;
    wa_idx  = '0;
    wa_data = '0;
    wb_en   = 1'b0;
    wb_idx  = '0;
    wb_data = '0;

    if (state_q == S_EXEC) begin
      wa_en   = 1'b1;
      wa_idx  = nos_idx;
      wa_data = alu_y;
      sp_d    = sp_q - SP_W'(1);
      carry_d = alu_c;
      upd_d   = 1'b1;
      lk_d    = LK_OP;
      state_d = S_SHOW;
    end else if (bus.Undo_pulse) begin
      if (lk_q == LK_OP) begin
        wa_en   = 1'b1;
        wa_idx  = tos_idx;
        wa_data = a_q;
        wb_en   = 1'b1;
        wb_idx  = sp_idx;
        wb_data = b_q;
        sp_d    = sp_q + SP_W'(1);
        lk_d    = LK_PUSH;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end else if (sp_q != '0) begin
        sp_d    = sp_q - SP_W'(1);
        err_d   = 1'b0;
        state_d = S_IDLE;
      end else begin
        err_d = 1'b1;
      end
    end else if (bus.Enter_pulse) begin
      if (!bus.IsOp) begin
        if (sp_q != SP_W'(DEPTH)) begin
          wa_en   = 1'b1;
          wa_idx  = sp_idx;
          wa_data = bus.DataIn;
          sp_d    = sp_q + SP_W'(1);
          lk_d    = LK_PUSH;
          carry_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          err_d = 1'b1;
        end
      end else if (sp_q >= SP_W'(2)) begin
        a_d     = stack_q[nos_idx];
        b_d     = stack_q[tos_idx];
        op_d    = opcode_t'(bus.OpCode);
        err_d   = 1'b0;
        state_d = S_EXEC;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      lk_q    <= LK_NONE;
      op_q    <= OP_ADD;
      sp_q    <= '0;
      err_q   <= 1'b0;
      carry_q <= 1'b0;
      upd_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      lk_q    <= lk_d;
      op_q    <= op_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
      carry_q <= carry_d;
      upd_q   <= upd_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Contents are meaningless once Sp is cleared, so the array needs no reset.
  always_ff @(posedge clk) begin
    if (wa_en) stack_q[wa_idx] <= wa_data;
    if (wb_en) stack_q[wb_idx] <= wb_data;
  end

  assign bus.Top          = (sp_q == '0) ? '0 : stack_q[tos_idx];
  assign bus.Sp           = sp_q;
  assign bus.Status       = state_q;
  assign bus.Full         = (sp_q == SP_W'(DEPTH));
  assign bus.Empty        = (sp_q == '0);
  assign bus.Error        = err_q;
  assign bus.Carry        = carry_q;
  assign bus.ToDisplaySel = (state_q == S_SHOW);
  assign bus.updateRes    = upd_q;
endmodule
